// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
// Holds the controller state encoding and the bit-counter sizing rule.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // A 1-bit operand still needs a 1-bit counter, so $clog2 is clamped at 1.
    function automatic int cntWidth(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: x - y - bin.
// Standalone so the gate-level version can be checked against it in isolation.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH cycles using one
// full-subtractor cell and a borrow register, with a start/done handshake.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int            CW   = cntWidth(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             armed_q;
    logic             cellDiff;
    logic             cellBout;
    logic             accept;
    logic [WIDTH-1:0] diffShifted;

    full_subtractor uCell (
        .x    (aSh_q[0]),
        .y    (bSh_q[0]),
        .bin  (borrow_q),
        .diff (cellDiff),
        .bout (cellBout)
    );

    if (WIDTH == 1) begin : gNarrow
        assign diffShifted = cellDiff;
    end else begin : gWide
        assign diffShifted = {cellDiff, diff_q[WIDTH-1:1]};
    end

    // armed_q stays low for the first edge after reset release, so a start
    // coinciding with deassertion is dropped.
    assign accept = armed_q & start & ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d  = state_q;
        aSh_d    = aSh_q;
        bSh_d    = bSh_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    aSh_d    = a;
                    bSh_d    = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end else begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                aSh_d    = aSh_q >> 1;
                bSh_d    = bSh_q >> 1;
                borrow_d = cellBout;
                diff_d   = diffShifted;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    bout_d  = cellBout;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            aSh_q    <= '0;
            bSh_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            aSh_q    <= aSh_d;
            bSh_q    <= bSh_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            armed_q  <= 1'b1;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       start1, bin1, busy1, done1, bout1;
    logic [0:0] a1, b1, diff1;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Waits from the falling edge after acceptance until done, bounded to 40 cycles.
    task automatic waitDone8(output int cycles, output int busyCycles);
        cycles     = 0;
        busyCycles = 0;
        while (done8 !== 1'b1 && cycles < 40) begin
            if (busy8 === 1'b1) busyCycles++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic binv,
                                 output int cycles, output int busyCycles);
        @(negedge clk);
        a8 = av; b8 = bv; bin8 = binv; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        waitDone8(cycles, busyCycles);
    endtask

    task automatic finishCheck(input string tag, input logic [7:0] expDiff, input logic expBout,
                               input int cycles, input int busyCycles);
        checkOutput({tag, " done"}, done8, 1'b1);
        checkOutput({tag, " latency"}, cycles, 8);
        checkOutput({tag, " busy cycles"}, busyCycles, 8);
        checkOutput({tag, " diff"}, diff8, expDiff);
        checkOutput({tag, " bout"}, bout8, expBout);
        @(negedge clk);
        checkOutput({tag, " done pulse width"}, done8, 1'b0);
        checkOutput({tag, " diff hold"}, diff8, expDiff);
        checkOutput({tag, " bout hold"}, bout8, expBout);
    endtask

    initial begin
        int         cyc, bc, doneCount;
        logic [2:0] combo;
        logic [7:0] ra, rb;
        logic       rbin;
        logic [8:0] model;
        logic [1:0] truth1 [8];

        truth1 = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset busy", busy8, 1'b0);
        checkOutput("reset done", done8, 1'b0);
        checkOutput("reset diff", diff8, 8'h00);
        checkOutput("reset bout", bout8, 1'b0);
        #2 rst_n = 1'b1;

        applyStimulus(8'h5A, 8'h23, 1'b0, cyc, bc);
        finishCheck("5A-23", 8'h37, 1'b0, cyc, bc);
        applyStimulus(8'h00, 8'h01, 1'b0, cyc, bc);
        finishCheck("00-01", 8'hFF, 1'b1, cyc, bc);
        applyStimulus(8'hFF, 8'hFF, 1'b1, cyc, bc);
        finishCheck("FF-FF-1", 8'hFF, 1'b1, cyc, bc);
        applyStimulus(8'h80, 8'h00, 1'b1, cyc, bc);
        finishCheck("80-00-1", 8'h7F, 1'b0, cyc, bc);

        // start held high during SHIFT with other operands must be ignored
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'h99; b8 = 8'h99;
        doneCount = 0;
        for (int i = 0; i < 5; i++) begin
            if (done8 === 1'b1) doneCount++;
            @(negedge clk);
        end
        start8 = 1'b0;
        waitDone8(cyc, bc);
        checkOutput("ignore latency", cyc, 3);
        checkOutput("ignore diff", diff8, 8'h10);
        checkOutput("ignore bout", bout8, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (done8 === 1'b1) doneCount++;
            @(negedge clk);
        end
        checkOutput("ignore done count", doneCount, 1);
        checkOutput("ignore no requeue", busy8, 1'b0);

        // back-to-back: start already high while DONE is showing
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h23; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        waitDone8(cyc, bc);
        checkOutput("b2b first done", done8, 1'b1);
        checkOutput("b2b first diff", diff8, 8'h37);
        a8 = 8'h03; b8 = 8'h05; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        checkOutput("b2b busy rise", busy8, 1'b1);
        checkOutput("b2b done low", done8, 1'b0);
        waitDone8(cyc, bc);
        finishCheck("03-05", 8'hFE, 1'b1, cyc, bc);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("shift bout stable", bout8, 1'b1);
        checkOutput("shift busy", busy8, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async busy", busy8, 1'b0);
        checkOutput("async done", done8, 1'b0);
        checkOutput("async diff", diff8, 8'h00);
        checkOutput("async bout", bout8, 1'b0);
        doneCount = 0;
        repeat (3) begin
            @(negedge clk);
            if (done8 === 1'b1) doneCount++;
        end
        #2 rst_n = 1'b1;
        @(negedge clk);
        if (done8 === 1'b1) doneCount++;
        checkOutput("reset no done", doneCount, 0);
        checkOutput("post reset idle", busy8, 1'b0);
        applyStimulus(8'h10, 8'h10, 1'b0, cyc, bc);
        finishCheck("10-10", 8'h00, 1'b0, cyc, bc);

        // WIDTH=1 truth table, done two cycles after the start cycle
        for (int i = 0; i < 8; i++) begin
            combo = i[2:0];
            @(negedge clk);
            a1 = combo[2]; b1 = combo[1]; bin1 = combo[0]; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            checkOutput($sformatf("w1 busy %0d", i), busy1, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("w1 done %0d", i), done1, 1'b1);
            checkOutput($sformatf("w1 result %0d", i), {bout1, diff1}, truth1[i]);
            @(negedge clk);
            checkOutput($sformatf("w1 done drop %0d", i), done1, 1'b0);
        end

        for (int n = 0; n < 1000; n++) begin
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            rbin  = 1'($urandom);
            model = {1'b0, ra} - {1'b0, rb} - {8'b0, rbin};
            applyStimulus(ra, rb, rbin, cyc, bc);
            checkOutput($sformatf("rand %0h-%0h-%0d", ra, rb, rbin), {done8, bout8, diff8}, {1'b1, model});
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
